imul_accumulator: RTL

Multiply-accumulate back end for the 16x16 unsigned array multiplier. Consumes one 32-bit product per accepted transfer and sums a burst of products into a wide accumulator. Presents the final sum to the next stage through a valid/ready handshake. Sits directly downstream of the combinational multiplier in the experimento2 datapath.

---
 rtl/imul_accumulator_if.sv | 27 ++
 rtl/imul_accumulator.sv | 93 +++++++++
 2 files changed

// File: rtl/imul_accumulator_if.sv
// Product-stream and result handshake bundle for imul_accumulator.
//   in_valid/in_ready/product/last : product stream (master drives, slave accepts)
//   out_valid/out_ready            : result handshake (slave presents, master accepts)
//   result/count/overflow          : held sum, term count, sticky overflow flag
interface imul_accumulator_if #(
  parameter int unsigned ACC_WIDTH = 40
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          product;
  logic                 last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] result;
  logic [8:0]           count;
  logic                 overflow;

  modport master (
    output in_valid, product, last, out_ready,
    input  in_ready, out_valid, result, count, overflow
  );

  modport slave (
    input  in_valid, product, last, out_ready,
    output in_ready, out_valid, result, count, overflow
  );
endinterface

// File: rtl/imul_accumulator.sv
// Multiply-accumulate back end: sums a burst of 32-bit unsigned products into an
// ACC_WIDTH-bit accumulator and offers the finished sum through a valid/ready handshake.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clear_i : synchronous abort/clear, overrides any transfer or result handshake
//   bus     : imul_accumulator_if.slave (product stream in, result handshake out)
// Build option: define IMUL_ACC_SATURATE_EN to clamp the sum at 2^ACC_WIDTH-1 on overflow;
// otherwise the sum wraps. The overflow flag is set in both cases.
module imul_accumulator #(
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned MAX_TERMS = 256
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic               clear_i,
  imul_accumulator_if.slave bus
);

  localparam int unsigned PadW     = ACC_WIDTH - 32;
  localparam logic [8:0]  MaxTerms = 9'(MAX_TERMS);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [8:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 end_burst;

  // Running-sum datapath, one bit wider than the accumulator to catch the carry.
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, {PadW{1'b0}}, bus.product};
    count_d   = count_q + 9'd1;
    ovf_d     = ovf_q | sum[ACC_WIDTH];
`ifdef IMUL_ACC_SATURATE_EN
    // Once saturated the sum stays pinned at all-ones for the rest of the burst.
    acc_d     = ovf_d ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    acc_d     = sum[ACC_WIDTH-1:0];
`endif
    end_burst = bus.last || (count_d == MaxTerms);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            // First term loads rather than adds, so the previous held sum is discarded.
            acc_q   <= {{PadW{1'b0}}, bus.product};
            count_q <= 9'd1;
            ovf_q   <= 1'b0;
            state_q <= (bus.last || (MaxTerms == 9'd1)) ? StHold : StAccum;
          end
        end
        StAccum: begin
          if (bus.in_valid) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= end_burst ? StHold : StAccum;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs come from state only: no input-to-output combinational path.
  assign bus.in_ready  = (state_q != StHold);
  assign bus.out_valid = (state_q == StHold);
  assign bus.result    = acc_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;

endmodule
